// File: rtl/mutative_types.sv
// ----------------------------------------------------------------------------
// mutative_types
//  Shared type/constant package for the mutative cache.
//  Holds the cacheline geometry, the memory-beat geometry used by
//  mutative_mem_adapter, the adapter FSM state type and a saturating adder
//  used by the optional performance counters.
// ----------------------------------------------------------------------------
package mutative_types;

   localparam int CACHELINE_SIZE = 256;                       // bits per line
   localparam int ADDR_BITS      = 32;                        // byte address
   localparam int OFFSET_BITS    = $clog2(CACHELINE_SIZE / 8); // byte offset in line

   localparam int BEAT_BITS      = 64;
   localparam int BEATS          = CACHELINE_SIZE / BEAT_BITS;
   localparam int BEAT_IDX_BITS  = $clog2(BEATS);

   typedef struct packed {
      logic [ADDR_BITS-OFFSET_BITS-1:0] line;
      logic [OFFSET_BITS-1:0]           offset;
   } cache_address_t;

   typedef enum logic [2:0] {
      IDLE,
      WR_BURST,
      RD_REQ,
      RD_BURST,
      RESP
   } adapter_state_t;

   // a + b, clamped at all-ones
   function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
   endfunction

endpackage

// File: rtl/mutative_mem_adapter.sv
// ----------------------------------------------------------------------------
// mutative_mem_adapter
//  Downstream stage of the mutative cache. Turns one 256-bit line fill or
//  write-back into a 4-beat 64-bit burst on the memory port and returns the
//  completion (plus fill data) to the cache with a one-cycle cache_resp.
//  One transaction outstanding; the cache holds its request until cache_resp.
//
//  Ports
//   clk, rst_n          clock, synchronous active-low reset
//   cache_read/write    fill / write-back request (write wins if both)
//   cache_addr          byte address, line offset ignored
//   cache_wdata         write-back line
//   cache_rdata         fill line, valid with cache_resp after a read
//   cache_resp          one-cycle completion pulse
//   bmem_addr           line-aligned burst address, constant per burst
//   bmem_read           read burst request, held until bmem_ready
//   bmem_write/wdata    write beat valid / data (beat 0 = line[63:0])
//   bmem_ready          accepts read request or current write beat
//   bmem_rdata/rvalid   read beat data / valid (beat 0 = line[63:0])
//
//  Build option MUT_ADAPTER_PERF_EN adds perf_rd_cnt, perf_wr_cnt and
//  perf_stall_cnt (saturating, updated on the edge that enters RESP).
// ----------------------------------------------------------------------------
module mutative_mem_adapter
   import mutative_types::*;
(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      cache_read,
   input  logic                      cache_write,
   input  logic [ADDR_BITS-1:0]      cache_addr,
   input  logic [CACHELINE_SIZE-1:0] cache_wdata,
   output logic [CACHELINE_SIZE-1:0] cache_rdata,
   output logic                      cache_resp,
   output logic [ADDR_BITS-1:0]      bmem_addr,
   output logic                      bmem_read,
   output logic                      bmem_write,
   output logic [BEAT_BITS-1:0]      bmem_wdata,
   input  logic                      bmem_ready,
   input  logic [BEAT_BITS-1:0]      bmem_rdata,
   input  logic                      bmem_rvalid
`ifdef MUT_ADAPTER_PERF_EN
   ,
   output logic [31:0]               perf_rd_cnt,
   output logic [31:0]               perf_wr_cnt,
   output logic [31:0]               perf_stall_cnt
`endif
);

   localparam int CL_BITS = CACHELINE_SIZE;
   localparam logic [BEAT_IDX_BITS-1:0] LAST_BEAT = BEAT_IDX_BITS'(BEATS - 1);

   adapter_state_t            state_q, state_d;
   logic [BEAT_IDX_BITS-1:0]  beat_cnt_q, beat_cnt_d;
   logic [CL_BITS-1:0]        line_q, line_d;
   logic [CL_BITS-1:0]        rdata_q, rdata_d;
   logic [ADDR_BITS-1:0]      addr_q, addr_d;
   logic [BEAT_BITS-1:0]      wdata_q, wdata_d;
   logic                      resp_q, resp_d;
   logic                      rd_q, rd_d;
   logic                      wr_q, wr_d;
   cache_address_t            aligned_addr;

   // Clear the byte offset so the burst always starts on the line boundary
   always_comb begin
      aligned_addr        = cache_addr;
      aligned_addr.offset = '0;
   end

   always_comb begin
      state_d    = state_q;
      beat_cnt_d = beat_cnt_q;
      line_d     = line_q;
      rdata_d    = rdata_q;
      addr_d     = addr_q;

      case (state_q)
         IDLE: begin
            beat_cnt_d = '0;
            if (cache_write) begin
               addr_d  = aligned_addr;
               line_d  = cache_wdata;
               state_d = WR_BURST;
            end else if (cache_read) begin
               addr_d  = aligned_addr;
               state_d = RD_REQ;
            end
         end
         WR_BURST: begin
            if (bmem_ready) begin
               beat_cnt_d = beat_cnt_q + 1'b1;
               if (beat_cnt_q == LAST_BEAT) state_d = RESP;
            end
         end
         RD_REQ: begin
            if (bmem_ready) begin
               state_d = RD_BURST;
               // memory may return beat 0 in the same cycle it accepts
               if (bmem_rvalid) begin
                  rdata_d[beat_cnt_q*BEAT_BITS +: BEAT_BITS] = bmem_rdata;
                  beat_cnt_d = beat_cnt_q + 1'b1;
               end
            end
         end
         RD_BURST: begin
            if (bmem_rvalid) begin
               rdata_d[beat_cnt_q*BEAT_BITS +: BEAT_BITS] = bmem_rdata;
               beat_cnt_d = beat_cnt_q + 1'b1;
               if (beat_cnt_q == LAST_BEAT) state_d = RESP;
            end
         end
         RESP: begin
            beat_cnt_d = '0;
            state_d    = IDLE;
         end
         default: begin
            beat_cnt_d = '0;
            state_d    = IDLE;
         end
      endcase

      // Outputs are registered: derive them from the state being entered
      resp_d  = (state_d == RESP);
      rd_d    = (state_d == RD_REQ);
      wr_d    = (state_d == WR_BURST);
      wdata_d = wr_d ? line_d[beat_cnt_d*BEAT_BITS +: BEAT_BITS] : '0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         beat_cnt_q <= '0;
         line_q     <= '0;
         rdata_q    <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         resp_q     <= 1'b0;
         rd_q       <= 1'b0;
         wr_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         beat_cnt_q <= beat_cnt_d;
         line_q     <= line_d;
         rdata_q    <= rdata_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         resp_q     <= resp_d;
         rd_q       <= rd_d;
         wr_q       <= wr_d;
      end
   end

   // Fill data lives in its own output register so a later write-back
   // reusing the line buffer cannot disturb what the cache already holds.
   assign cache_rdata = rdata_q;
   assign cache_resp  = resp_q;
   assign bmem_addr   = addr_q;
   assign bmem_read   = rd_q;
   assign bmem_write  = wr_q;
   assign bmem_wdata  = wdata_q;

`ifdef MUT_ADAPTER_PERF_EN
   logic [31:0] stall_acc_q, stall_acc_d;
   logic [31:0] perf_rd_q, perf_rd_d;
   logic [31:0] perf_wr_q, perf_wr_d;
   logic [31:0] perf_stall_q, perf_stall_d;
   logic        in_burst;

   assign in_burst = (state_q == WR_BURST) || (state_q == RD_REQ) || (state_q == RD_BURST);

   // Stalls are gathered per transaction and folded in when RESP is entered
   always_comb begin
      stall_acc_d  = stall_acc_q;
      perf_rd_d    = perf_rd_q;
      perf_wr_d    = perf_wr_q;
      perf_stall_d = perf_stall_q;
      if (state_q == IDLE) begin
         stall_acc_d = '0;
      end else if (in_burst && !bmem_ready && !bmem_rvalid) begin
         stall_acc_d = sat_add32(stall_acc_q, 32'd1);
      end
      if (state_d == RESP && state_q != RESP) begin
         if (state_q == RD_BURST) perf_rd_d = sat_add32(perf_rd_q, 32'd1);
         else                     perf_wr_d = sat_add32(perf_wr_q, 32'd1);
         perf_stall_d = sat_add32(perf_stall_q, stall_acc_q);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_acc_q  <= '0;
         perf_rd_q    <= '0;
         perf_wr_q    <= '0;
         perf_stall_q <= '0;
      end else begin
         stall_acc_q  <= stall_acc_d;
         perf_rd_q    <= perf_rd_d;
         perf_wr_q    <= perf_wr_d;
         perf_stall_q <= perf_stall_d;
      end
   end

   assign perf_rd_cnt    = perf_rd_q;
   assign perf_wr_cnt    = perf_wr_q;
   assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_mutative_mem_adapter.sv
// ----------------------------------------------------------------------------
// tb_mutative_mem_adapter
//  Directed bench for mutative_mem_adapter. Driver tasks issue cache
//  requests and play the memory side; expected write beats, read requests
//  and cache responses are queued as they are issued, and a negedge monitor
//  pops and compares whenever the DUT presents the matching output.
//  Define MUT_ADAPTER_PERF_EN to also exercise the performance counters.
// ----------------------------------------------------------------------------
module tb_mutative_mem_adapter;

   typedef struct {
      logic [31:0] addr;
      logic [63:0] data;
   } beat_t;

   typedef struct {
      logic [31:0] addr;
      int          hold;
   } rdreq_t;

   typedef struct {
      bit           is_read;
      logic [255:0] rdata;
      int           cyc;
   } resp_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         cache_read = 1'b0;
   logic         cache_write = 1'b0;
   logic [31:0]  cache_addr = '0;
   logic [255:0] cache_wdata = '0;
   logic [255:0] cache_rdata;
   logic         cache_resp;
   logic [31:0]  bmem_addr;
   logic         bmem_read;
   logic         bmem_write;
   logic [63:0]  bmem_wdata;
   logic         bmem_ready = 1'b0;
   logic [63:0]  bmem_rdata = '0;
   logic         bmem_rvalid = 1'b0;
`ifdef MUT_ADAPTER_PERF_EN
   logic [31:0]  perf_rd_cnt;
   logic [31:0]  perf_wr_cnt;
   logic [31:0]  perf_stall_cnt;
`endif

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int rd_hold = 0;

   beat_t  exp_beat_q[$];
   rdreq_t exp_rdreq_q[$];
   resp_t  exp_resp_q[$];

   mutative_mem_adapter dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cache_read  (cache_read),
      .cache_write (cache_write),
      .cache_addr  (cache_addr),
      .cache_wdata (cache_wdata),
      .cache_rdata (cache_rdata),
      .cache_resp  (cache_resp),
      .bmem_addr   (bmem_addr),
      .bmem_read   (bmem_read),
      .bmem_write  (bmem_write),
      .bmem_wdata  (bmem_wdata),
      .bmem_ready  (bmem_ready),
      .bmem_rdata  (bmem_rdata),
      .bmem_rvalid (bmem_rvalid)
`ifdef MUT_ADAPTER_PERF_EN
      ,
      .perf_rd_cnt    (perf_rd_cnt),
      .perf_wr_cnt    (perf_wr_cnt),
      .perf_stall_cnt (perf_stall_cnt)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_chk++;
      n_fail++;
      $display("FAIL %s: event missing or unexpected", name);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, ".cache_resp"},  256'(cache_resp),  256'd0);
      chk({tag, ".bmem_read"},   256'(bmem_read),   256'd0);
      chk({tag, ".bmem_write"},  256'(bmem_write),  256'd0);
      chk({tag, ".bmem_addr"},   256'(bmem_addr),   256'd0);
      chk({tag, ".bmem_wdata"},  256'(bmem_wdata),  256'd0);
      chk({tag, ".cache_rdata"}, cache_rdata,       256'd0);
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (bmem_write && bmem_ready) begin
         if (exp_beat_q.size() == 0) fail_now("unexpected_wr_beat");
         else begin
            beat_t e;
            e = exp_beat_q.pop_front();
            chk("wr_beat_addr", 256'(bmem_addr), 256'(e.addr));
            chk("wr_beat_data", 256'(bmem_wdata), 256'(e.data));
            $display("[%0d] write beat addr=%h data=%h", cyc, bmem_addr, bmem_wdata);
         end
      end
      if (bmem_read) begin
         rd_hold++;
         if (bmem_ready) begin
            if (exp_rdreq_q.size() == 0) fail_now("unexpected_rd_req");
            else begin
               rdreq_t r;
               r = exp_rdreq_q.pop_front();
               chk("rd_req_addr", 256'(bmem_addr), 256'(r.addr));
               chk("rd_req_hold", 256'(rd_hold), 256'(r.hold));
               $display("[%0d] read request addr=%h held %0d cycles", cyc, bmem_addr, rd_hold);
            end
            rd_hold = 0;
         end
      end else begin
         rd_hold = 0;
      end
      if (cache_resp) begin
         if (exp_resp_q.size() == 0) fail_now("unexpected_cache_resp");
         else begin
            resp_t p;
            p = exp_resp_q.pop_front();
            chk("resp_cycle", 256'(cyc), 256'(p.cyc));
            if (p.is_read) chk("fill_rdata", cache_rdata, p.rdata);
            $display("[%0d] cache_resp read=%0d rdata=%h", cyc, p.is_read, cache_rdata);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_write(input logic [31:0] a, input logic [255:0] line, input bit with_read);
      int  c;
      bit  got;
      logic [31:0] al;
      tick;
      cache_write = 1'b1;
      cache_read  = with_read;
      cache_addr  = a;
      cache_wdata = line;
      bmem_ready  = 1'b1;
      c  = cyc;
      al = {a[31:5], 5'b0};
      for (int k = 0; k < 4; k++) exp_beat_q.push_back('{addr: al, data: line[k*64 +: 64]});
      exp_resp_q.push_back('{is_read: 1'b0, rdata: '0, cyc: c + 5});
      got = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick;
         if (cache_resp) begin got = 1'b1; break; end
      end
      if (!got) fail_now("write_timeout");
      tick;
      cache_write = 1'b0;
      cache_read  = 1'b0;
      bmem_ready  = 1'b0;
   endtask

   task automatic do_read(input logic [31:0] a, input logic [255:0] line,
                          input int req_wait, input int gap);
      int c;
      int k;
      bit got;
      tick;
      cache_read  = 1'b1;
      cache_addr  = a;
      bmem_ready  = 1'b0;
      bmem_rvalid = 1'b0;
      c = cyc;
      exp_rdreq_q.push_back('{addr: {a[31:5], 5'b0}, hold: req_wait + 1});
      exp_resp_q.push_back('{is_read: 1'b1, rdata: line, cyc: c + 6 + req_wait + 4*gap});
      got = 1'b0;
      for (int i = 1; i <= 80; i++) begin
         tick;
         bmem_ready  = (i == 1 + req_wait);
         k = i - (2 + req_wait + gap);
         bmem_rvalid = 1'b0;
         if (k >= 0 && (k % (gap + 1)) == 0 && (k / (gap + 1)) < 4) begin
            bmem_rvalid = 1'b1;
            bmem_rdata  = line[(k / (gap + 1))*64 +: 64];
         end
         if (cache_resp) begin got = 1'b1; break; end
      end
      if (!got) fail_now("read_timeout");
      tick;
      cache_read  = 1'b0;
      bmem_ready  = 1'b0;
      bmem_rvalid = 1'b0;
   endtask

   logic [255:0] line_v;

   initial begin
      // Reset held for two cycles
      rst_n = 1'b0;
      tick;
      tick;
      chk_idle_outputs("reset");
      rst_n = 1'b1;
      // Random read beats while idle must be ignored
      for (int i = 0; i < 5; i++) begin
         tick;
         bmem_rvalid = 1'($urandom_range(0, 1));
         bmem_rdata  = {$urandom, $urandom};
      end
      tick;
      bmem_rvalid = 1'b0;
      tick;
      chk_idle_outputs("idle_rvalid");

      // Write-back, zero-wait memory
      line_v = {64'hD, 64'hC, 64'hB, 64'hA};
      do_write(32'h0000_1234, line_v, 1'b0);

      // Fill: request accepted after 3 cycles, beats with 2-cycle gaps
      line_v = {64'h4, 64'h3, 64'h2, 64'h1};
      do_read(32'h0000_0040, line_v, 2, 2);

      // Simultaneous read and write: write only, read re-presented afterwards
      line_v = {64'h1111_0004, 64'h1111_0003, 64'h1111_0002, 64'h1111_0001};
      do_write(32'h0000_2000, line_v, 1'b1);
      line_v = {64'hAAAA_0004, 64'hAAAA_0003, 64'hAAAA_0002, 64'hAAAA_0001};
      do_read(32'h0000_2000, line_v, 0, 0);
      chk("fill_rdata_hold", cache_rdata, line_v);

      // Reset during beat 2 of a fill
      tick;
      cache_read = 1'b1;
      cache_addr = 32'h0000_0080;
      bmem_ready = 1'b1;
      exp_rdreq_q.push_back('{addr: 32'h0000_0080, hold: 1});
      tick;                                   // RD_REQ, accepted
      tick; bmem_rvalid = 1'b1; bmem_rdata = 64'h11;
      tick; bmem_rdata = 64'h22;
      tick; bmem_rdata = 64'h33; rst_n = 1'b0;
      tick;
      rst_n = 1'b1; cache_read = 1'b0; bmem_ready = 1'b0; bmem_rvalid = 1'b0;
      chk_idle_outputs("mid_fill_reset");
      line_v = {64'h5555_0004, 64'h5555_0003, 64'h5555_0002, 64'h5555_0001};
      do_write(32'h0000_3008, line_v, 1'b0);

`ifdef MUT_ADAPTER_PERF_EN
      // Counters from a fresh reset: 2 fills, 1 write-back, 3 stall cycles
      tick; rst_n = 1'b0;
      tick; rst_n = 1'b1;
      line_v = {64'h7, 64'h6, 64'h5, 64'h4};
      do_read(32'h0000_0100, line_v, 2, 0);
      do_read(32'h0000_0140, line_v, 1, 0);
      do_write(32'h0000_0180, line_v, 1'b0);
      tick;
      chk("perf_rd_cnt",    256'(perf_rd_cnt),    256'd2);
      chk("perf_wr_cnt",    256'(perf_wr_cnt),    256'd1);
      chk("perf_stall_cnt", 256'(perf_stall_cnt), 256'd3);
      dut.perf_rd_q = 32'hFFFF_FFFF;
      do_read(32'h0000_01C0, line_v, 0, 0);
      tick;
      chk("perf_rd_saturate", 256'(perf_rd_cnt), 256'(32'hFFFF_FFFF));
`endif

      repeat (3) tick;
      chk("beats_left",  256'(exp_beat_q.size()),  256'd0);
      chk("rdreqs_left", 256'(exp_rdreq_q.size()), 256'd0);
      chk("resps_left",  256'(exp_resp_q.size()),  256'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
